// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg : shared types and constants for the audio sample buffer.
//   play_state_t  - read-side state (PRIMING / PLAYING)
//   SILENCE_U8    - mid-scale silence for unsigned 8-bit audio
//   SILENCE_S16   - silence for signed 16-bit audio
//   lvl_w()       - width of a 0..depth level counter
// ---------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic {PRIMING = 1'b0, PLAYING = 1'b1} play_state_t;

    localparam logic [7:0]  SILENCE_U8  = 8'h80;
    localparam logic [15:0] SILENCE_S16 = 16'h0000;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/audio_sample_fifo_if.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo_if : byte-in / sample-out bus of audio_sample_fifo.
//   master : byte producer + sample consumer (drives flush, bytes, strobe)
//   slave  : the FIFO (drives ready, sample, flags, level)
// ---------------------------------------------------------------------------
interface audio_sample_fifo_if
    import audio_pkg::*;
#(
    parameter int BYTES_PER_SAMPLE = 2,
    parameter int DEPTH            = 64
);
    localparam int SAMPLE_W = 8 * BYTES_PER_SAMPLE;
    localparam int LEVEL_W  = lvl_w(DEPTH);

    logic                flush_in;
    logic [7:0]          byte_in;
    logic                byte_valid_in;
    logic                byte_ready_out;
    logic                sample_strobe_in;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid_out;
    logic                underrun_out;
    logic                playing_out;
    logic [LEVEL_W-1:0]  level_out;
    logic                almost_full_out;

    modport master (
        output flush_in, byte_in, byte_valid_in, sample_strobe_in,
        input  byte_ready_out, sample_out, sample_valid_out, underrun_out,
               playing_out, level_out, almost_full_out
    );

    modport slave (
        input  flush_in, byte_in, byte_valid_in, sample_strobe_in,
        output byte_ready_out, sample_out, sample_valid_out, underrun_out,
               playing_out, level_out, almost_full_out
    );
endinterface

// File: rtl/audio_sample_fifo_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer : assembles BYTES_PER_SAMPLE bytes little-endian into a word.
//   clk_in, rst_n_in : clock, async active-low reset
//   flush_in         : drop any partial word, restart at lane 0
//   byte_in          : data byte, taken when accept_in is high
//   word_out         : assembled word (valid with word_valid_out)
//   word_valid_out   : the accepted byte completes a word this cycle
// ---------------------------------------------------------------------------
module byte_packer #(
    parameter int BYTES_PER_SAMPLE = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          flush_in,
    input  logic [7:0]                    byte_in,
    input  logic                          accept_in,
    output logic [8*BYTES_PER_SAMPLE-1:0] word_out,
    output logic                          word_valid_out
);
    localparam int CNT_W = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_SAMPLE - 1);

    logic [CNT_W-1:0]              r_count;
    logic [8*BYTES_PER_SAMPLE-1:0] r_asm;
    logic [8*BYTES_PER_SAMPLE-1:0] w_word;

    // The incoming byte is merged combinationally so the completing byte
    // lands in the buffer in the same cycle it is accepted.
    always_comb begin
        w_word = r_asm;
        for (int i = 0; i < BYTES_PER_SAMPLE; i++)
            if (r_count == CNT_W'(i)) w_word[8*i +: 8] = byte_in;
    end

    assign word_out       = w_word;
    assign word_valid_out = accept_in && (r_count == LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
            r_asm   <= '0;
        end else if (flush_in) begin
            r_count <= '0;
        end else if (accept_in) begin
            r_asm   <= w_word;
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end
endmodule

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo : byte-packing circular sample buffer with a priming
// read FSM, between the SD byte reader and the audio output stage.
//   clk_in, rst_n_in : clock, async active-low reset
//   bus (slave)      : flush, byte handshake, sample strobe, sample output,
//                      valid/underrun pulses, playing, level, almost-full
// Build option: AUDIO_FIFO_HOLD_LAST_EN - underrun/priming strobes hold the
// last sample instead of outputting SILENCE_VALUE.
// ---------------------------------------------------------------------------
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int BYTES_PER_SAMPLE = 2,
    parameter int DEPTH            = 64,
    parameter int PRIME_LEVEL      = 32,
    parameter int AF_MARGIN        = 8,
    parameter logic [8*BYTES_PER_SAMPLE-1:0] SILENCE_VALUE = '0
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    audio_sample_fifo_if.slave  bus
);
    localparam int SAMPLE_W = 8 * BYTES_PER_SAMPLE;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LEVEL_W  = lvl_w(DEPTH);
    localparam logic [LEVEL_W-1:0] FULL_LVL  = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] PRIME_LVL = LEVEL_W'(PRIME_LEVEL);
    localparam logic [LEVEL_W-1:0] AF_LVL    = LEVEL_W'(DEPTH - AF_MARGIN);

    logic [SAMPLE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [LEVEL_W-1:0]  r_level, w_level_nxt;
    logic                r_af, r_sv, r_ur;
    logic [SAMPLE_W-1:0] r_sample, w_idle_val, w_word;
    play_state_t         r_state, w_state_nxt;
    logic                w_full, w_accept, w_push, w_strobe_play, w_pop, w_underrun;

    // Full comes from the registered level, so a same-cycle pop never
    // makes room for a byte.
    assign w_full   = (r_level == FULL_LVL);
    assign w_accept = bus.byte_valid_in && !w_full && !bus.flush_in;

    byte_packer #(.BYTES_PER_SAMPLE(BYTES_PER_SAMPLE)) u_packer (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .flush_in       (bus.flush_in),
        .byte_in        (bus.byte_in),
        .accept_in      (w_accept),
        .word_out       (w_word),
        .word_valid_out (w_push)
    );

    // No empty bypass: a push landing with a strobe at level 0 is an underrun.
    assign w_strobe_play = bus.sample_strobe_in && (r_state == PLAYING);
    assign w_pop         = w_strobe_play && (r_level != '0);
    assign w_underrun    = w_strobe_play && (r_level == '0);

`ifdef AUDIO_FIFO_HOLD_LAST_EN
    assign w_idle_val = r_sample;
`else
    assign w_idle_val = SILENCE_VALUE;
`endif

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)      w_level_nxt = r_level + 1'b1;
        else if (!w_push && w_pop) w_level_nxt = r_level - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PRIMING: if (r_level >= PRIME_LVL) w_state_nxt = PLAYING;
            PLAYING: if (w_underrun)           w_state_nxt = PRIMING;
        endcase
        if (bus.flush_in) w_state_nxt = PRIMING;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= PRIMING;
        else           r_state <= w_state_nxt;
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wptr] <= w_word;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_af     <= 1'b0;
            r_sample <= SILENCE_VALUE;
            r_sv     <= 1'b0;
            r_ur     <= 1'b0;
        end else if (bus.flush_in) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_af     <= 1'b0;
            r_sample <= SILENCE_VALUE;
            r_sv     <= 1'b0;
            r_ur     <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= w_level_nxt;
            r_af    <= (w_level_nxt >= AF_LVL);
            r_sv    <= w_pop;
            r_ur    <= w_underrun;
            if (w_pop)                     r_sample <= r_mem[r_rptr];
            else if (bus.sample_strobe_in) r_sample <= w_idle_val;
        end
    end

    assign bus.byte_ready_out   = !w_full;
    assign bus.sample_out       = r_sample;
    assign bus.sample_valid_out = r_sv;
    assign bus.underrun_out     = r_ur;
    assign bus.playing_out      = (r_state == PLAYING);
    assign bus.level_out        = r_level;
    assign bus.almost_full_out  = r_af;
endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;
    import audio_pkg::*;

    localparam int BPS   = 2;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_sample_fifo_if #(.BYTES_PER_SAMPLE(BPS), .DEPTH(DEPTH)) bus ();

    audio_sample_fifo #(
        .BYTES_PER_SAMPLE(BPS), .DEPTH(DEPTH), .PRIME_LEVEL(32),
        .AF_MARGIN(8), .SILENCE_VALUE(16'h0000)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic       fl;
        logic [7:0] b;
        logic       bv;
        logic       stb;
        logic       e_ready;
        logic [6:0] e_level;
        logic [15:0] e_sample;
        logic       e_sv;
        logic       e_ur;
        logic       e_play;
        logic       e_af;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] q[$];
    logic [15:0] last_out;
    logic [15:0] exp_ur_val;
    vec_t vt[6];

    function automatic vec_t mk(input logic fl, input logic [7:0] b, input logic bv,
                                input logic stb, input logic rdy, input logic [6:0] lvl,
                                input logic [15:0] smp, input logic sv, input logic ur,
                                input logic ply, input logic af);
        vec_t v;
        v.fl = fl; v.b = b; v.bv = bv; v.stb = stb;
        v.e_ready = rdy; v.e_level = lvl; v.e_sample = smp;
        v.e_sv = sv; v.e_ur = ur; v.e_play = ply; v.e_af = af;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic fl, input logic [7:0] b, input logic bv, input logic stb);
        bus.flush_in         = fl;
        bus.byte_in          = b;
        bus.byte_valid_in    = bv;
        bus.sample_strobe_in = stb;
        @(posedge clk);
        #1;
        bus.flush_in         = 1'b0;
        bus.byte_valid_in    = 1'b0;
        bus.sample_strobe_in = 1'b0;
    endtask

    task automatic push_sample(input logic [15:0] s);
        step(1'b0, s[7:0], 1'b1, 1'b0);
        step(1'b0, s[15:8], 1'b1, 1'b0);
        q.push_back(s);
    endtask

    task automatic strobe_pop(input string name);
        logic [15:0] e;
        e = q.pop_front();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk({name, "_sample"}, bus.sample_out, e);
        chk({name, "_valid"}, bus.sample_valid_out, 1);
        last_out = e;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"},    bus.byte_ready_out, 1);
        chk({tag, "_level"},    bus.level_out, 0);
        chk({tag, "_sample"},   bus.sample_out, 0);
        chk({tag, "_valid"},    bus.sample_valid_out, 0);
        chk({tag, "_underrun"}, bus.underrun_out, 0);
        chk({tag, "_playing"},  bus.playing_out, 0);
        chk({tag, "_af"},       bus.almost_full_out, 0);
    endtask

    initial begin
        bus.flush_in = 1'b0; bus.byte_in = 8'h00;
        bus.byte_valid_in = 1'b0; bus.sample_strobe_in = 1'b0;
        last_out = 16'h0000;

        //           fl  byte  bv  stb  rdy lvl smp     sv  ur  ply af
        vt[0] = mk(0, 8'h34, 1, 0,  1,  0, 16'h0, 0, 0, 0, 0);
        vt[1] = mk(0, 8'h12, 1, 0,  1,  1, 16'h0, 0, 0, 0, 0);
        vt[2] = mk(0, 8'h00, 0, 1,  1,  1, 16'h0, 0, 0, 0, 0);
        vt[3] = mk(0, 8'h78, 1, 1,  1,  1, 16'h0, 0, 0, 0, 0);
        vt[4] = mk(0, 8'h56, 1, 0,  1,  2, 16'h0, 0, 0, 0, 0);
        vt[5] = mk(0, 8'h00, 0, 0,  1,  2, 16'h0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // Short priming-phase sequence: packing, strobes while priming.
        for (int i = 0; i < 6; i++) begin
            step(vt[i].fl, vt[i].b, vt[i].bv, vt[i].stb);
            chk($sformatf("v%0d_ready", i),  bus.byte_ready_out,   vt[i].e_ready);
            chk($sformatf("v%0d_level", i),  bus.level_out,        vt[i].e_level);
            chk($sformatf("v%0d_sample", i), bus.sample_out,       vt[i].e_sample);
            chk($sformatf("v%0d_valid", i),  bus.sample_valid_out, vt[i].e_sv);
            chk($sformatf("v%0d_ur", i),     bus.underrun_out,     vt[i].e_ur);
            chk($sformatf("v%0d_play", i),   bus.playing_out,      vt[i].e_play);
            chk($sformatf("v%0d_af", i),     bus.almost_full_out,  vt[i].e_af);
        end
        q.push_back(16'h1234);
        q.push_back(16'h5678);

        // Fill to the prime level; playing follows one cycle later.
        for (int i = 0; i < 30; i++) push_sample(16'h0A00 + 16'(i));
        chk("prime_level", bus.level_out, 32);
        chk("prime_play0", bus.playing_out, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("prime_play1", bus.playing_out, 1);

        strobe_pop("pop0");
        chk("pop0_level", bus.level_out, 31);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pop0_valid_drop", bus.sample_valid_out, 0);
        strobe_pop("pop1");
        chk("pop1_level", bus.level_out, 30);

        // Fill to full, watching the almost-full threshold at 56.
        for (int i = 0; i < 34; i++) begin
            push_sample(16'hC000 + 16'(i));
            chk($sformatf("fill%0d_level", i), bus.level_out, 31 + i);
            chk($sformatf("fill%0d_af", i), bus.almost_full_out, (31 + i >= 56) ? 1 : 0);
        end
        chk("full_ready", bus.byte_ready_out, 0);

        // Strobe with a byte offered while full: pop happens, byte refused.
        step(1'b0, 8'hEE, 1'b1, 1'b1);
        chk("fullpop_sample", bus.sample_out, q.pop_front());
        chk("fullpop_level", bus.level_out, 63);
        chk("fullpop_ready", bus.byte_ready_out, 1);
        step(1'b0, 8'h11, 1'b1, 1'b0);
        chk("refill_lo_level", bus.level_out, 63);
        step(1'b0, 8'h22, 1'b1, 1'b0);
        chk("refill_hi_level", bus.level_out, 64);
        q.push_back(16'h2211);

        // Drain everything back-to-back.
        for (int i = 0; i < 64; i++) begin
            strobe_pop($sformatf("drain%0d", i));
            chk($sformatf("drain%0d_level", i), bus.level_out, 63 - i);
            chk($sformatf("drain%0d_af", i), bus.almost_full_out, (63 - i >= 56) ? 1 : 0);
        end

`ifdef AUDIO_FIFO_HOLD_LAST_EN
        exp_ur_val = last_out;
`else
        exp_ur_val = 16'h0000;
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ur_pulse", bus.underrun_out, 1);
        chk("ur_valid", bus.sample_valid_out, 0);
        chk("ur_play", bus.playing_out, 0);
        chk("ur_sample", bus.sample_out, exp_ur_val);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("prime_strobe_ur", bus.underrun_out, 0);
        chk("prime_strobe_sample", bus.sample_out, exp_ur_val);

        // Flush discards a stored sample and a partial byte; flush-cycle byte refused.
        step(1'b0, 8'h21, 1'b1, 1'b0);
        step(1'b0, 8'h43, 1'b1, 1'b0);
        step(1'b0, 8'h99, 1'b1, 1'b0);
        chk("preflush_level", bus.level_out, 1);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("flush_level", bus.level_out, 0);
        chk("flush_sample", bus.sample_out, 0);
        chk("flush_play", bus.playing_out, 0);
        q.delete();
        push_sample(16'hBBAA);
        chk("postflush_level", bus.level_out, 1);
        for (int i = 0; i < 31; i++) push_sample(16'h3000 + 16'(i));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("reprime_play", bus.playing_out, 1);
        strobe_pop("flushpop");
        for (int i = 0; i < 11; i++) strobe_pop($sformatf("pre_rst%0d", i));
        chk("pre_rst_level", bus.level_out, 20);

        // Asynchronous reset well away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Parametrised audio sample buffer between the SD-card byte reader (`song_selection`) and the audio output stage.
- Write side: accepts one byte per handshake, packs `BYTES_PER_SAMPLE` bytes little-endian into one sample and stores it in an internal circular buffer of `DEPTH` samples.
- Read side: pops one sample per sample-rate strobe. A priming state machine holds off playback until enough samples are buffered. Underruns are flagged and answered with silence.
- Replaces the fixed 8-bit vendor FIFO and its hand-sequenced write/read FSM.

## Interface
Parameters:
- `BYTES_PER_SAMPLE`, 2: bytes packed per sample, 1..4; `SAMPLE_W` = 8·`BYTES_PER_SAMPLE`.
- `DEPTH`, 64: sample entries, power of two, ≥ 4.
- `PRIME_LEVEL`, 32: fill level required to leave PRIMING, 1..`DEPTH`.
- `AF_MARGIN`, 8: `almost_full_out` asserts when level ≥ `DEPTH`−`AF_MARGIN`.
- `SILENCE_VALUE`, 0: `SAMPLE_W`-bit value output when no sample is available.

Ports:
- `clk_in` in 1: single clock (25 MHz domain). One clock; reset is asynchronous and active-low.
- `rst_n_in` in 1: asynchronous active-low reset.
- `flush_in` in 1: synchronous clear (song change).
- `byte_in` in 8: SD data byte.
- `byte_valid_in` in 1: byte offered.
- `byte_ready_out` out 1: byte accepted when valid & ready.
- `sample_strobe_in` in 1: one-cycle pulse at the audio sample rate.
- `sample_out` out `SAMPLE_W`: current output sample, registered.
- `sample_valid_out` out 1: one-cycle pulse, `sample_out` updated from the buffer.
- `underrun_out` out 1: one-cycle pulse, strobe arrived in PLAYING with the buffer empty.
- `playing_out` out 1: read FSM is in PLAYING.
- `level_out` out clog2(`DEPTH`+1): stored samples; partial packer content is not counted.
- `almost_full_out` out 1: level threshold flag.

## Operation
- Reset values:
  - `sample_out` = `SILENCE_VALUE`.
  - `sample_valid_out`, `underrun_out`, `playing_out`, `almost_full_out` = 0.
  - `level_out` = 0.
  - Pointers, packer count and FSM state = PRIMING.
  - `byte_ready_out` = 1.
- Packer:
  - Byte counter 0..`BYTES_PER_SAMPLE`−1. An accepted byte goes to lane `count` (lane 0 = bits 7:0).
  - On the last lane the assembled word is written to the buffer in the same cycle and the counter wraps to 0.
- `byte_ready_out` = !full. It is computed from registered level, so a pop in the same cycle does not admit a byte.
- Pointers: write/read pointers are clog2(`DEPTH`) bits and wrap naturally. Full and empty are derived from the level counter, not from pointer compare.
- Level:
  - +1 on push only, −1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds `DEPTH` and never goes below 0.
- Read FSM:
  - PRIMING: strobes drive `sample_out` = `SILENCE_VALUE`, no pop, no `underrun_out`. → PLAYING when level ≥ `PRIME_LEVEL`.
  - PLAYING, strobe with level > 0: pop; `sample_out` = head entry; `sample_valid_out` pulses.
  - PLAYING, strobe with level == 0: `underrun_out` pulses; output per Configuration; → PRIMING.
- Empty bypass: there is none. A push and a strobe in the same cycle with level 0 counts as an underrun.
- `flush_in`:
  - Clears pointers, level and packer count, discarding any partial sample; FSM → PRIMING.
  - `sample_out` → `SILENCE_VALUE`.
  - Flush has priority over any same-cycle push or pop; the byte offered that cycle is not accepted.
- Async reset mid-transfer: discards everything; no recovery of partial samples.

## Timing
- Strobe in cycle N → `sample_out`/`sample_valid_out`/`underrun_out` valid in cycle N+1.
- Byte completing a sample in cycle N → `level_out` incremented in N+1; poppable by a strobe in N+1.
- PRIMING→PLAYING: state changes in the cycle after level reaches `PRIME_LEVEL`. The first pop is on the next strobe after that.
- `almost_full_out` is registered alongside the level and updates with it.
- Throughput: one byte per cycle on the write side; one sample per strobe on the read side. Strobes spaced ≥ 1 cycle apart are all honoured.

## Configuration
- `AUDIO_FIFO_HOLD_LAST_EN`:
  - Defined: an underrun holds the previous `sample_out` value (avoids a click on short underruns). PRIMING after an underrun also holds that value.
  - Undefined: an underrun and PRIMING drive `SILENCE_VALUE`.
- Flush and reset output `SILENCE_VALUE` in both cases.

## Structure
- Shared package `audio_pkg`:
  - `typedef enum logic {PRIMING, PLAYING} play_state_t`.
  - Default `SILENCE_VALUE` constants for 8/16-bit audio.
- Sub-module `byte_packer`: lane counter and assembly register; outputs word plus `word_valid`. The buffer, level logic and FSM stay in the top module.
- Storage is a plain register array (`DEPTH`×`SAMPLE_W`), inferable as distributed RAM.

## Test plan
- Reset, then push bytes 0x34,0x12 (BPS=2): level 0→1; after 31 more samples and a strobe, `sample_out`=0x1234 with `sample_valid_out` one cycle after the strobe.
- Strobes while level < 32: `sample_out`=0, no `underrun_out`, `playing_out`=0. Reaching 32 → `playing_out`=1 next cycle.
- Fill to 64: `byte_ready_out`=0, `almost_full_out`=1 from level 56. A strobe with valid byte in the same cycle: level 63, byte not accepted.
- In PLAYING, drain to 0, then strobe: `underrun_out` pulses, `playing_out`=0, `sample_out`=0 (macro off) or last sample (macro on).
- Push one byte (partial), then `flush_in`: level 0, next two bytes 0xAA,0xBB yield sample 0xBBAA.
- Deassert `rst_n_in` asynchronously mid-fill at level 20: all outputs return to reset values without waiting for a clock edge.
